io_instruction_sequencer: RTL

//  Sits between the CPU execute unit and the IOP wrapper. Accepts one SIO/TIO request from the CPU.

---
 rtl/iop_defs_pkg.sv | 31 +++
 rtl/io_instruction_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/iop_defs_pkg.sv
// Shared IOP definitions: function codes, command orders, the status-word address,
// condition-code constants and the sequencer state encoding.
package iop_defs_pkg;

  localparam logic [0:2] FNC_SIO = 3'd0;
  localparam logic [0:2] FNC_TIO = 3'd1;

  localparam logic [0:3] CMD_ORDER_WRITE   = 4'h1;
  localparam logic [0:3] CMD_ORDER_READ    = 4'h2;
  localparam logic [0:3] CMD_ORDER_CONTROL = 4'h3;
  localparam logic [0:3] CMD_ORDER_SENSE   = 4'h4;

  localparam logic [15:31] IOP_STATUS_ADDR = 17'h00021;

  localparam logic [0:1] CC_NOT_OPERATIONAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } seq_state_t;

  // A status-word write is any byte write landing on the status address.
  function automatic logic is_status_write(input logic [15:31] addr,
                                           input logic [0:3]   wr_en,
                                           input logic [15:31] status_addr);
    return (wr_en != 4'b0000) && (addr == status_addr);
  endfunction

endpackage

// File: rtl/io_instruction_sequencer.sv
// Hands one SIO/TIO from the CPU to the IOP and returns the IOP condition code with an ack.
// Optional watchdog abort in WAIT is enabled by defining IO_TIMEOUT_EN.
module io_instruction_sequencer
  import iop_defs_pkg::*;
#(
`ifdef IO_TIMEOUT_EN
  parameter int             TIMEOUT_CYCLES = 4096,
`endif
  parameter logic [15:31]   STATUS_ADDR    = IOP_STATUS_ADDR
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic [0:2]    cpu_func,
  input  logic [21:31]  cpu_device,
  output logic          cpu_busy,
  output logic          cpu_ack,
  output logic [0:1]    cpu_cc,
  output logic          timeout,
  output logic          iop_active,
  output logic [0:2]    iop_func,
  output logic [21:31]  iop_device,
  input  logic [0:1]    iop_cc,
  input  logic [15:31]  iop_mem_addr,
  input  logic [0:3]    iop_wr_en
);

  seq_state_t  state;
  seq_state_t  state_next;
  logic        active_next;
  logic        busy_next;
  logic        ack_next;
  logic        timeout_next;
  logic [0:1]  cc_next;
  logic        accept;
  logic        status_seen;
  logic        expired;

  assign status_seen = is_status_write(iop_mem_addr, iop_wr_en, STATUS_ADDR);

`ifdef IO_TIMEOUT_EN
  logic [12:0] wdog;
  logic [12:0] wdog_next;

  assign expired = (wdog == 13'(TIMEOUT_CYCLES - 1));

  // Watchdog counts completed WAIT cycles; cleared when an operation is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdog <= 13'd0;
    end else begin
      wdog <= wdog_next;
    end
  end

  always_comb begin
    wdog_next = wdog;
    if (accept) begin
      wdog_next = 13'd0;
    end else if (state == WAIT) begin
      wdog_next = wdog + 13'd1;
    end else begin
      wdog_next = wdog;
    end
  end
`else
  assign expired = 1'b0;
`endif

  // Next-state and next-output decode.
  always_comb begin
    state_next   = state;
    active_next  = iop_active;
    ack_next     = 1'b0;
    timeout_next = 1'b0;
    cc_next      = cpu_cc;
    accept       = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          state_next  = WAIT;
          active_next = 1'b1;
          accept      = 1'b1;
        end else begin
          active_next = 1'b0;
        end
      end
      WAIT: begin
        // A status write on the expiry cycle is a normal completion.
        if (status_seen) begin
          state_next = SETTLE;
        end else if (expired) begin
          state_next   = DONE;
          active_next  = 1'b0;
          ack_next     = 1'b1;
          timeout_next = 1'b1;
          cc_next      = CC_NOT_OPERATIONAL;
        end else begin
          state_next = WAIT;
        end
      end
      SETTLE: begin
        state_next  = DONE;
        active_next = 1'b0;
        ack_next    = 1'b1;
        cc_next     = iop_cc;
      end
      DONE: begin
        state_next  = IDLE;
        active_next = 1'b0;
      end
      default: begin
        state_next  = IDLE;
        active_next = 1'b0;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  // State and all outputs are registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      iop_active <= 1'b0;
      cpu_busy   <= 1'b0;
      cpu_ack    <= 1'b0;
      timeout    <= 1'b0;
      cpu_cc     <= 2'b00;
      iop_func   <= 3'd0;
      iop_device <= 11'd0;
    end else begin
      state      <= state_next;
      iop_active <= active_next;
      cpu_busy   <= busy_next;
      cpu_ack    <= ack_next;
      timeout    <= timeout_next;
      cpu_cc     <= cc_next;
      if (accept) begin
        iop_func   <= cpu_func;
        iop_device <= cpu_device;
      end else begin
        iop_func   <= iop_func;
        iop_device <= iop_device;
      end
    end
  end

endmodule
